// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : Fabric-side byte handshake between an SPI target and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if;
    logic       iSend;
    logic [7:0] iData;
    logic       oTaken;
    logic [7:0] oData;
    logic       oAvail;
    logic       oTxFull;
    logic       oUnderrun;
    logic       oBusy;

    modport slave (
        input  iSend, iData,
        output oTaken, oData, oAvail, oTxFull, oUnderrun, oBusy
    );

    modport master (
        output iSend, iData,
        input  oTaken, oData, oAvail, oTxFull, oUnderrun, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Mode-0 SPI target, oversampling SCK/MOSI/CS_n in the iClk domain.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  wire logic  iClk,
    input  wire logic  iRst,
    spi_slave_if.slave bus,
    input  wire logic  iSck,
    input  wire logic  iMosi,
    input  wire logic  iCsN,
    output logic       oMiso
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic                   r_sckHist;
    logic                   r_csHist;

    state_t     r_state;
    logic [7:0] r_shiftOut;
    logic [6:0] r_rxShift;
    logic [2:0] r_bitCnt;
    logic       r_reloadPend;
    logic [7:0] r_hold;
    logic       r_txFull;
    logic       r_taken;
    logic       r_avail;
    logic       r_underrun;
    logic [7:0] r_data;
    logic       r_miso;

    logic       w_sck;
    logic       w_cs;
    logic       w_mosi;
    logic       w_sckRise;
    logic       w_sckFall;
    logic       w_csRise;
    logic       w_csFall;
    logic       w_active;
    logic       w_abort;
    logic       w_start;
    logic       w_rxEdge;
    logic       w_txEdge;
    logic       w_load;
    logic [7:0] w_loadByte;
    logic [7:0] w_rxByte;
    logic [7:0] w_shiftNext;
    state_t     w_stateNext;

    assign w_sck  = r_sckSync[SYNC_STAGES-1];
    assign w_cs   = r_csSync[SYNC_STAGES-1];
    assign w_mosi = r_mosiSync[SYNC_STAGES-1];

    assign w_sckRise = w_sck & ~r_sckHist;
    assign w_sckFall = ~w_sck & r_sckHist;
    assign w_csRise  = w_cs & ~r_csHist;
    assign w_csFall  = ~w_cs & r_csHist;

    // A CS_n release overrides any SCK edge seen in the same cycle.
    assign w_active = (r_state == ACTIVE);
    assign w_abort  = w_active & w_csRise;
    assign w_start  = ~w_active & w_csFall;
    assign w_rxEdge = w_active & ~w_csRise & w_sckRise;
    assign w_txEdge = w_active & ~w_csRise & w_sckFall;
    assign w_load   = w_start | (w_txEdge & r_reloadPend);

    assign w_loadByte = r_txFull ? r_hold : UNDERRUN_BYTE;
    assign w_rxByte   = {r_rxShift, w_mosi};

    always_comb begin
        w_shiftNext = r_shiftOut;
        w_stateNext = r_state;
        if (w_abort) begin
            w_shiftNext = 8'hFF;
            w_stateNext = IDLE;
        end else if (w_load) begin
            w_shiftNext = w_loadByte;
        end else if (w_txEdge) begin
            w_shiftNext = {r_shiftOut[6:0], 1'b1};
        end
        if (w_start) begin
            w_stateNext = ACTIVE;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_sckSync    <= '0;
            r_mosiSync   <= '0;
            r_csSync     <= '1;
            r_sckHist    <= 1'b0;
            r_csHist     <= 1'b1;
            r_state      <= IDLE;
            r_shiftOut   <= 8'hFF;
            r_rxShift    <= '0;
            r_bitCnt     <= '0;
            r_reloadPend <= 1'b0;
            r_hold       <= '0;
            r_txFull     <= 1'b0;
            r_taken      <= 1'b0;
            r_avail      <= 1'b0;
            r_underrun   <= 1'b0;
            r_data       <= '0;
            r_miso       <= 1'b1;
        end else begin
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], iSck};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], iMosi};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], iCsN};
            r_sckHist  <= w_sck;
            r_csHist   <= w_cs;

            r_state    <= w_stateNext;
            r_shiftOut <= w_shiftNext;
            r_miso     <= (w_stateNext == ACTIVE) ? w_shiftNext[7] : 1'b1;

            r_taken    <= 1'b0;
            r_avail    <= 1'b0;
            r_underrun <= 1'b0;

            if (w_abort) begin
                r_bitCnt     <= '0;
                r_reloadPend <= 1'b0;
            end else if (w_start) begin
                r_bitCnt <= '0;
            end else if (w_rxEdge) begin
                r_rxShift <= w_rxByte[6:0];
                r_bitCnt  <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) begin
                    r_data       <= w_rxByte;
                    r_avail      <= 1'b1;
                    r_reloadPend <= 1'b1;
                end
            end else if (w_txEdge && r_reloadPend) begin
                r_reloadPend <= 1'b0;
            end

            // A load sees the holding register as it was entering this cycle;
            // a same-cycle iSend into an empty register still lands afterwards.
            if (w_load) begin
                r_underrun <= ~r_txFull;
                r_txFull   <= 1'b0;
            end
            if (bus.iSend && !r_txFull) begin
                r_hold   <= bus.iData;
                r_txFull <= 1'b1;
                r_taken  <= 1'b1;
            end
        end
    end

    assign bus.oTaken    = r_taken;
    assign bus.oData     = r_data;
    assign bus.oAvail    = r_avail;
    assign bus.oTxFull   = r_txFull;
    assign bus.oUnderrun = r_underrun;
    assign bus.oBusy     = w_active;
    assign oMiso         = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Scoreboard bench driving directed SPI mode-0 transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int HALF = 8;

    logic iClk  = 1'b0;
    logic iRst  = 1'b1;
    logic iSck  = 1'b0;
    logic iMosi = 1'b0;
    logic iCsN  = 1'b1;
    logic oMiso;

    spi_slave_if bus();

    spi_slave #(
        .SYNC_STAGES   (2),
        .UNDERRUN_BYTE (8'hFF)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .bus   (bus.slave),
        .iSck  (iSck),
        .iMosi (iMosi),
        .iCsN  (iCsN),
        .oMiso (oMiso)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int errors   = 0;
    int takenCnt = 0;
    int urCnt    = 0;
    int availCnt = 0;

    logic [7:0] rxQ[$];
    logic [7:0] misoQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receive-side monitor: every oAvail pops the next expected byte.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (bus.oTaken)    takenCnt++;
            if (bus.oUnderrun) urCnt++;
            if (bus.oAvail) begin
                availCnt++;
                if (rxQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx unexpected oAvail: got %0h expected none", bus.oData);
                end else begin
                    check("rx byte", 32'(bus.oData), 32'(rxQ.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic expTaken);
        bus.iSend = 1'b1;
        bus.iData = d;
        tick(1);
        bus.iSend = 1'b0;
        check("oTaken", 32'(bus.oTaken), 32'(expTaken));
    endtask

    task automatic spiByte(input logic [7:0] m, input int nBits, input logic chk);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < nBits; i++) begin
            iMosi = m[7-i];
            tick(HALF);
            got  = {got[6:0], oMiso};
            iSck = 1'b1;
            tick(HALF);
            iSck = 1'b0;
        end
        tick(HALF);
        if (chk) begin
            if (misoQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso byte: got %0h expected none", got);
            end else begin
                check("miso byte", 32'(got), 32'(misoQ.pop_front()));
            end
        end
    endtask

    task automatic csLow();
        iCsN = 1'b0;
        tick(HALF);
    endtask

    task automatic csHigh();
        iCsN = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic doReset();
        iRst  = 1'b1;
        iSck  = 1'b0;
        iCsN  = 1'b1;
        iMosi = 1'b0;
        bus.iSend = 1'b0;
        tick(2);
        iRst = 1'b0;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int u0;
        bus.iSend = 1'b0;
        bus.iData = '0;

        // Reset state, preload, and a push while full being ignored
        doReset();
        check("reset oMiso", 32'(oMiso), 32'h1);
        check("reset oBusy", 32'(bus.oBusy), 32'h0);
        check("reset oTxFull", 32'(bus.oTxFull), 32'h0);
        check("reset oData", 32'(bus.oData), 32'h0);
        push(8'hA5, 1'b1);
        check("oTxFull after push", 32'(bus.oTxFull), 32'h1);
        push(8'h3C, 1'b0);
        csLow();
        check("oBusy active", 32'(bus.oBusy), 32'h1);
        misoQ.push_back(8'hA5);
        rxQ.push_back(8'h11);
        spiByte(8'h11, 8, 1'b1);
        csHigh();
        check("oBusy idle", 32'(bus.oBusy), 32'h0);

        // Single byte: 3C out, C3 in
        doReset();
        a0 = availCnt;
        push(8'h3C, 1'b1);
        csLow();
        misoQ.push_back(8'h3C);
        rxQ.push_back(8'hC3);
        spiByte(8'hC3, 8, 1'b1);
        csHigh();
        check("single oAvail count", 32'(availCnt - a0), 32'd1);
        check("oData C3", 32'(bus.oData), 32'hC3);
        check("oTxFull drained", 32'(bus.oTxFull), 32'h0);

        // Two bytes with a refill during byte 1
        doReset();
        a0 = availCnt;
        push(8'h81, 1'b1);
        csLow();
        push(8'h7E, 1'b1);
        misoQ.push_back(8'h81);
        misoQ.push_back(8'h7E);
        rxQ.push_back(8'h01);
        rxQ.push_back(8'h02);
        spiByte(8'h01, 8, 1'b1);
        spiByte(8'h02, 8, 1'b1);
        csHigh();
        check("two-byte oAvail count", 32'(availCnt - a0), 32'd2);

        // Underrun at CS fall, push-while-full ignored
        doReset();
        u0 = urCnt;
        csLow();
        check("underrun at CS fall", 32'(urCnt - u0), 32'd1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        misoQ.push_back(8'hFF);
        rxQ.push_back(8'h00);
        spiByte(8'h00, 8, 1'b1);
        check("no underrun on refill", 32'(urCnt - u0), 32'd1);
        misoQ.push_back(8'h11);
        rxQ.push_back(8'h00);
        spiByte(8'h00, 8, 1'b1);
        csHigh();

        // CS abort after 5 bits, then clean byte
        doReset();
        csLow();
        misoQ.push_back(8'hFF);
        rxQ.push_back(8'h24);
        spiByte(8'h24, 8, 1'b1);
        a0 = availCnt;
        spiByte(8'hFF, 5, 1'b0);
        csHigh();
        check("abort no oAvail", 32'(availCnt - a0), 32'd0);
        check("abort oData kept", 32'(bus.oData), 32'h24);
        csLow();
        misoQ.push_back(8'hFF);
        rxQ.push_back(8'h5A);
        spiByte(8'h5A, 8, 1'b1);
        csHigh();
        check("oData 5A", 32'(bus.oData), 32'h5A);

        // Asynchronous reset mid-byte
        doReset();
        push(8'hC0, 1'b1);
        csLow();
        push(8'h33, 1'b1);
        spiByte(8'hFF, 3, 1'b0);
        check("mid-byte oMiso", 32'(oMiso), 32'h0);
        iRst = 1'b1;
        #1;
        check("async oBusy", 32'(bus.oBusy), 32'h0);
        check("async oMiso", 32'(oMiso), 32'h1);
        check("async oTxFull", 32'(bus.oTxFull), 32'h0);
        iCsN = 1'b1;
        doReset();
        push(8'h69, 1'b1);
        csLow();
        misoQ.push_back(8'h69);
        rxQ.push_back(8'h96);
        spiByte(8'h96, 8, 1'b1);
        csHigh();
        check("oData 96", 32'(bus.oData), 32'h96);

        tick(4);
        check("rx queue drained", 32'(rxQ.size()), 32'd0);
        check("miso queue drained", 32'(misoQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
Mode-0 (CPOL=0, CPHA=0) SPI responder operating entirely in the iClk domain by oversampling the external SCK, MOSI and CS_n pins.
- Receive side: presents each received byte with a one-cycle strobe.
- Transmit side: takes bytes through a one-deep holding register with a taken strobe, the same byte-level handshake the fabric uses with the SPI initiator.
- Used where the FPGA is an SPI target of an external MCU or host.

Parameters:
SYNC_STAGES, 2, synchronizer flops on iSck/iMosi/iCsN (minimum 2)
UNDERRUN_BYTE, 8'hFF, byte shifted out when no TX byte is held at a byte boundary

Ports:
iClk  in  1  system clock; all logic on posedge
iRst  in  1  asynchronous active-high reset
iSend  in  1  request to load iData into the TX holding register
iData  in  8  TX byte
oTaken  out  1  one-cycle pulse: iData accepted into holding register
oData  out  8  last received byte; stable until next oAvail
oAvail  out  1  one-cycle pulse: oData updated
oTxFull  out  1  holding register occupied; iSend ignored while high
oUnderrun  out  1  one-cycle pulse: UNDERRUN_BYTE loaded instead of held byte
oBusy  out  1  synchronized CS_n is low (transaction active)
iSck  in  1  SPI clock pin (async)
iMosi  in  1  SPI data in pin (async)
iCsN  in  1  SPI chip select pin, active low (async)
oMiso  out  1  SPI data out

Behaviour:
- Reset (async assert; release takes effect on the next posedge):
  - oTaken=oAvail=oUnderrun=0, oData=0, oTxFull=0, oBusy=0.
  - Shift-out register = 8'hFF, oMiso=1.
  - Bit counter=0, reload-pending=0, synchronizers set to idle (SCK=0, CS_n=1).
- Synchronizing and edge detection:
  - Pins pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - A pin change is acted on SYNC_STAGES+1 cycles after it occurs.
  - Requirement: each SCK high and low phase ≥ SYNC_STAGES+2 iClk periods. Faster SCK is undefined.
- States: IDLE (sync CS_n=1) and ACTIVE (sync CS_n=0). oBusy=1 exactly in ACTIVE.
- CS_n falling edge (IDLE->ACTIVE):
  - Bit counter=0.
  - Load shift-out: if oTxFull, take the held byte and clear oTxFull; else load UNDERRUN_BYTE and pulse oUnderrun.
- SCK rising edge in ACTIVE:
  - Shift sampled MOSI into the receive shift register (MSB first); counter+1.
  - When counter was 7: oData <= completed byte, oAvail=1 the next cycle, counter=0, reload-pending=1.
- SCK falling edge in ACTIVE:
  - If reload-pending: load shift-out per the CS-fall rule and clear reload-pending.
  - Else: shift-out <= {shift-out[6:0],1}.
- oMiso = shift-out[7] in ACTIVE, 1 in IDLE (registered, no tristate; top level handles tristating).
- TX handshake:
  - iSend with oTxFull=0: holding <= iData, oTxFull=1, oTaken=1 the next cycle.
  - iSend with oTxFull=1: ignored, no oTaken.
  - Same cycle as a shift-out load:
    - The load consumes the holding register as it was before that cycle.
    - If the register was empty, UNDERRUN_BYTE is sent and iData lands in holding.
    - If it was full, the load empties it and iSend is ignored.
- CS_n rising mid-byte (counter≠0):
  - Partial receive bits discarded, no oAvail.
  - Counter=0, reload-pending=0, shift-out=8'hFF.
  - A byte already moved from holding into shift-out is lost; holding-register contents are kept.
- SCK edges while IDLE are ignored. A CS_n toggle with no SCK edges consumes one TX byte (or underruns).
- Reset mid-transaction: immediate return to reset state; the held TX byte is discarded.

Test Plan:
- Reset, no SPI activity -> oMiso=1, oBusy=0, oTxFull=0; iSend iData=8'hA5 -> oTaken pulses one cycle later, oTxFull=1.
- Preload 8'h3C, then CS low and 8 SCK cycles with MOSI=8'hC3 -> MISO bits 0,0,1,1,1,1,0,0; oData=8'hC3 with a single oAvail pulse; oTxFull=0.
- Two-byte transfer, 8'h81 held and 8'h7E pushed during byte 1 -> MISO 8'h81 then 8'h7E; oAvail pulses twice (MOSI 8'h01, 8'h02 captured in order).
- No preload, CS low, 8 clocks -> MISO 8'hFF, oUnderrun pulses once at CS fall; second iSend while oTxFull=1 -> no oTaken, holding unchanged.
- CS raised after 5 SCK rises -> no oAvail, oData unchanged; next full byte 8'h5A received correctly as 8'h5A.
- iRst asserted mid-byte -> outputs return to reset values immediately; after release, a fresh 8'h96 transfer completes correctly.
